// File: rtl/ecc_job_sequencer_if.sv
// Job / APB / result bundle for ecc_job_sequencer.
// The master modport is the sequencer's view. The slave modport is the view of the
// job source, the ECC block and the result sink.
interface ecc_job_sequencer_if #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
);
  // Job intake
  logic                       job_valid;
  logic                       job_ready;
  logic [AMBA_WORD-1:0]       job_data;
  logic [AMBA_WORD-1:0]       job_noise;
  logic [1:0]                 job_op;
  logic [1:0]                 job_width;
  // APB master toward the ECC block
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  // ECC block results
  logic [AMBA_WORD-1:0]       data_out;
  logic                       operation_done;
  logic [1:0]                 num_of_errors;
  // Result delivery
  logic                       res_valid;
  logic                       res_ready;
  logic [AMBA_WORD-1:0]       res_data;
  logic [1:0]                 res_errors;
  logic                       res_timeout;
  logic                       busy;

  modport master (
    input  job_valid, job_data, job_noise, job_op, job_width,
    input  data_out, operation_done, num_of_errors, res_ready,
    output job_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
    output res_valid, res_data, res_errors, res_timeout, busy
  );

  modport slave (
    output job_valid, job_data, job_noise, job_op, job_width,
    output data_out, operation_done, num_of_errors, res_ready,
    input  job_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
    input  res_valid, res_data, res_errors, res_timeout, busy
  );
endinterface

// File: rtl/ecc_job_sequencer.sv
// ecc_job_sequencer: accepts one ECC job at a time and programs the ECC block over APB
// with the write list DATA_IN, CODEWORD_WIDTH (skipped when unchanged), NOISE and CTRL.
// It then waits for operation_done and presents the result on a valid/ready port.
// Optional build macro ECC_SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog that gives up after
// TIMEOUT_CYCLES cycles and returns a zero result with res_timeout set.
module ecc_job_sequencer #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input logic                clk,
  input logic                rst,   // synchronous, active low
  ecc_job_sequencer_if.master bus
);

  if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 4..255");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_WAIT_DONE, S_RESP
  } state_e;

  typedef enum logic [1:0] {
    E_DATA, E_WIDTH, E_NOISE, E_CTRL
  } entry_e;

  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL  = AMBA_ADDR_WIDTH'(4'h0);
  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA  = AMBA_ADDR_WIDTH'(4'h4);
  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_WIDTH = AMBA_ADDR_WIDTH'(4'h8);
  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE = AMBA_ADDR_WIDTH'(4'hC);

  state_e               state, state_nxt;
  entry_e               entry, entry_after;

  logic [AMBA_WORD-1:0] job_data_q, job_noise_q;
  logic [1:0]           job_op_q, job_width_q;

  logic                 width_written;
  logic [1:0]           last_width;
  logic                 need_width;

  logic [AMBA_WORD-1:0] res_data_q;
  logic [1:0]           res_errors_q;

  logic                 accept;
  logic                 done_hit;
  logic                 timeout_hit;

  assign accept     = (state == S_IDLE) && bus.job_valid;
  assign done_hit   = (state == S_WAIT_DONE) && bus.operation_done;
  assign need_width = !width_written || (job_width_q != last_width);

`ifdef ECC_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       res_timeout_q;

  assign timeout_hit = (state == S_WAIT_DONE) && !bus.operation_done &&
                       (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles spent in WAIT_DONE, and records whether the result is a timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt      <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      if (state == S_WAIT_DONE) wait_cnt <= wait_cnt + 8'd1;
      else                      wait_cnt <= '0;
      if (done_hit)         res_timeout_q <= 1'b0;
      else if (timeout_hit) res_timeout_q <= 1'b1;
    end
  end

  assign bus.res_timeout = res_timeout_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.res_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default first keeps every path assigned, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (bus.job_valid) state_nxt = S_SETUP;
      S_SETUP:     state_nxt = S_ACCESS;
      S_ACCESS:    state_nxt = (entry == E_CTRL) ? S_WAIT_DONE : S_SETUP;
      S_WAIT_DONE: if (bus.operation_done || timeout_hit) state_nxt = S_RESP;
      S_RESP:      if (bus.res_ready) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Entry that follows the current one in the write list.
  always_comb begin
    entry_after = E_CTRL;
    unique case (entry)
      E_DATA:  entry_after = need_width ? E_WIDTH : E_NOISE;
      E_WIDTH: entry_after = E_NOISE;
      E_NOISE: entry_after = E_CTRL;
      default: entry_after = E_CTRL;
    endcase
  end

  // Job payload capture on accept.
  always_ff @(posedge clk) begin
    // NOTE: the payload is not reset. It reaches an output only while the FSM is in
    // SETUP/ACCESS, and a job is always accepted before then.
    if (accept) begin
      job_data_q  <= bus.job_data;
      job_noise_q <= bus.job_noise;
      job_op_q    <= bus.job_op;
      job_width_q <= bus.job_width;
    end
  end

  // Write-list walk, width-written tracking and result capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entry         <= E_DATA;
      width_written <= 1'b0;
      last_width    <= 2'd0;
      res_data_q    <= '0;
      res_errors_q  <= 2'd0;
    end else begin
      if (accept) entry <= E_DATA;
      else if (state == S_ACCESS && entry != E_CTRL) entry <= entry_after;

      if (state == S_ACCESS && entry == E_WIDTH) begin
        width_written <= 1'b1;
        last_width    <= job_width_q;
      end

      if (done_hit) begin
        res_data_q   <= bus.data_out;
        res_errors_q <= bus.num_of_errors;
      end else if (timeout_hit) begin
        res_data_q   <= '0;
        res_errors_q <= 2'd0;
      end
    end
  end

  // Output decode: APB drive, handshakes and status.
  always_comb begin
    bus.PSEL      = 1'b0;
    bus.PENABLE   = 1'b0;
    bus.PWRITE    = 1'b0;
    bus.PADDR     = '0;
    bus.PWDATA    = '0;
    bus.job_ready = (state == S_IDLE);
    bus.busy      = (state != S_IDLE);
    bus.res_valid = (state == S_RESP);
    if (state == S_SETUP || state == S_ACCESS) begin
      bus.PSEL    = 1'b1;
      bus.PWRITE  = 1'b1;
      bus.PENABLE = (state == S_ACCESS);
      unique case (entry)
        E_DATA:  begin bus.PADDR = ADDR_DATA;  bus.PWDATA = job_data_q;              end
        E_WIDTH: begin bus.PADDR = ADDR_WIDTH; bus.PWDATA = AMBA_WORD'(job_width_q); end
        E_NOISE: begin bus.PADDR = ADDR_NOISE; bus.PWDATA = job_noise_q;             end
        default: begin bus.PADDR = ADDR_CTRL;  bus.PWDATA = AMBA_WORD'(job_op_q);    end
      endcase
    end
  end

  assign bus.res_data   = res_data_q;
  assign bus.res_errors = res_errors_q;

endmodule

// File: tb/tb_ecc_job_sequencer.sv
// Directed bench for ecc_job_sequencer. It covers the reset state, full and short write
// lists, result capture with back-pressure, the WAIT_DONE timeout (or the indefinite wait
// when ECC_SEQ_TIMEOUT_EN is undefined) and a reset taken during the NOISE ACCESS cycle.
module tb_ecc_job_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ecc_job_sequencer_if #(.AMBA_ADDR_WIDTH(20), .AMBA_WORD(32)) bus();

  ecc_job_sequencer #(
    .AMBA_ADDR_WIDTH(20),
    .AMBA_WORD(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  int          wr_n;
  int          hit_cycle;
  logic [31:0] s1_psel, s1_pen, s1_pwrite, s1_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer a job and log every APB ACCESS until the access to stop_addr.
  // The task returns at the negedge of that access cycle. The cycle count starts at 1 on the first SETUP.
  task automatic send_job(input logic [31:0] d, input logic [31:0] n,
                          input logic [1:0] op, input logic [1:0] w,
                          input logic [31:0] stop_addr);
    @(negedge clk);
    bus.job_data  = d;
    bus.job_noise = n;
    bus.job_op    = op;
    bus.job_width = w;
    bus.job_valid = 1'b1;
    check("job_ready_idle", 32'(bus.job_ready), 32'd1);
    @(negedge clk);
    bus.job_valid = 1'b0;
    wr_n      = 0;
    hit_cycle = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) begin
        s1_psel   = 32'(bus.PSEL);
        s1_pen    = 32'(bus.PENABLE);
        s1_pwrite = 32'(bus.PWRITE);
        s1_addr   = 32'(bus.PADDR);
      end
      if (bus.PSEL && bus.PENABLE) begin
        if (wr_n < 8) begin
          wr_addr[wr_n] = 32'(bus.PADDR);
          wr_data[wr_n] = bus.PWDATA;
        end
        wr_n++;
        if (32'(bus.PADDR) == stop_addr) begin
          hit_cycle = c;
          break;
        end
      end
    end
  endtask

  // The task is entered at the negedge of the CTRL ACCESS cycle.
  // operation_done is raised in the delay-th WAIT_DONE cycle.
  // res_ready is then held low for stall cycles while another job is offered.
  task automatic finish_job(input int delay, input logic [31:0] dout,
                            input logic [1:0] errs, input int stall);
    logic [31:0] held;
    for (int i = 0; i < delay; i++) @(negedge clk);
    check("apb_idle_wait_done", 32'(bus.PSEL), 32'd0);
    bus.data_out       = dout;
    bus.num_of_errors  = errs;
    bus.operation_done = 1'b1;
    @(negedge clk);
    bus.operation_done = 1'b0;
    bus.data_out       = 32'hFFFF_FFFF;
    bus.num_of_errors  = 2'd0;
    check("res_valid_up", 32'(bus.res_valid), 32'd1);
    check("res_data", bus.res_data, dout);
    check("res_errors", 32'(bus.res_errors), 32'(errs));
    check("res_timeout_clear", 32'(bus.res_timeout), 32'd0);
    held = bus.res_data;
    bus.job_valid = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_res_valid", 32'(bus.res_valid), 32'd1);
      check("stall_res_data", bus.res_data, held);
      check("stall_job_ready", 32'(bus.job_ready), 32'd0);
    end
    bus.job_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("post_resp_valid", 32'(bus.res_valid), 32'd0);
    check("post_resp_job_ready", 32'(bus.job_ready), 32'd1);
  endtask

  initial begin
    int  n;
    logic seen_valid;

    rst                = 1'b0;
    bus.job_valid      = 1'b0;
    bus.job_data       = '0;
    bus.job_noise      = '0;
    bus.job_op         = 2'd0;
    bus.job_width      = 2'd0;
    bus.data_out       = '0;
    bus.operation_done = 1'b0;
    bus.num_of_errors  = 2'd0;
    bus.res_ready      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_job_ready", 32'(bus.job_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_psel", 32'(bus.PSEL), 32'd0);
    check("rst_penable", 32'(bus.PENABLE), 32'd0);
    check("rst_pwrite", 32'(bus.PWRITE), 32'd0);
    check("rst_paddr", 32'(bus.PADDR), 32'd0);
    check("rst_pwdata", bus.PWDATA, 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", bus.res_data, 32'd0);
    check("rst_res_errors", 32'(bus.res_errors), 32'd0);
    check("rst_res_timeout", 32'(bus.res_timeout), 32'd0);
    rst = 1'b1;

    // Job 1: first job after reset. Expect 4 writes, with CTRL ACCESS in cycle 8.
    send_job(32'h0000_00A5, 32'h0, 2'b10, 2'd2, 32'h0);
    check("j1_setup_psel", s1_psel, 32'd1);
    check("j1_setup_penable", s1_pen, 32'd0);
    check("j1_setup_pwrite", s1_pwrite, 32'd1);
    check("j1_setup_paddr", s1_addr, 32'h4);
    check("j1_nwrites", 32'(wr_n), 32'd4);
    check("j1_addr0", wr_addr[0], 32'h4);
    check("j1_data0", wr_data[0], 32'h0000_00A5);
    check("j1_addr1", wr_addr[1], 32'h8);
    check("j1_data1", wr_data[1], 32'h2);
    check("j1_addr2", wr_addr[2], 32'hC);
    check("j1_data2", wr_data[2], 32'h0);
    check("j1_addr3", wr_addr[3], 32'h0);
    check("j1_ctrl_data", wr_data[3], 32'h2);
    check("j1_ctrl_cycle", 32'(hit_cycle), 32'd8);
    check("j1_busy", 32'(bus.busy), 32'd1);
    finish_job(3, 32'h1234_5678, 2'd1, 5);

    // Job 2: same width. Expect 3 writes and no 0x8 write.
    send_job(32'hCAFE_0001, 32'h0000_0100, 2'b01, 2'd2, 32'h0);
    check("j2_nwrites", 32'(wr_n), 32'd3);
    check("j2_addr0", wr_addr[0], 32'h4);
    check("j2_addr1", wr_addr[1], 32'hC);
    check("j2_data1", wr_data[1], 32'h0000_0100);
    check("j2_addr2", wr_addr[2], 32'h0);
    check("j2_ctrl_cycle", 32'(hit_cycle), 32'd6);
    finish_job(1, 32'hDEAD_BEEF, 2'd3, 0);

    // Job 3: width changes to 1, so the 0x8 write comes back with PWDATA 1.
    send_job(32'h0000_0042, 32'h0000_0003, 2'b00, 2'd1, 32'h0);
    check("j3_nwrites", 32'(wr_n), 32'd4);
    check("j3_addr1", wr_addr[1], 32'h8);
    check("j3_data1", wr_data[1], 32'h1);
    check("j3_ctrl_data", wr_data[3], 32'h0);
    check("j3_ctrl_cycle", 32'(hit_cycle), 32'd8);
    finish_job(2, 32'h0000_0000, 2'd2, 0);

    // Job 4: operation_done never arrives.
    send_job(32'h5555_AAAA, 32'h0, 2'b10, 2'd1, 32'h0);
    check("j4_nwrites", 32'(wr_n), 32'd3);
    bus.data_out      = 32'hFFFF_FFFF;
    bus.num_of_errors = 2'd2;
`ifdef ECC_SEQ_TIMEOUT_EN
    n = 0;
    while (!bus.res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("to_resp_after_16", 32'(n), 32'd17);
    check("to_res_timeout", 32'(bus.res_timeout), 32'd1);
    check("to_res_data", bus.res_data, 32'd0);
    check("to_res_errors", 32'(bus.res_errors), 32'd0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("to_exit_idle", 32'(bus.job_ready), 32'd1);
`else
    repeat (40) @(negedge clk);
    check("nto_still_waiting", 32'(bus.res_valid), 32'd0);
    check("nto_busy", 32'(bus.busy), 32'd1);
    check("nto_timeout_zero", 32'(bus.res_timeout), 32'd0);
    finish_job(1, 32'h0BAD_F00D, 2'd0, 0);
`endif

    // Job 5: reset during the NOISE ACCESS cycle. The 4 writes start, and NOISE ACCESS falls in cycle 6.
    send_job(32'h1111_2222, 32'h0000_0008, 2'b01, 2'd2, 32'hC);
    check("j5_noise_cycle", 32'(hit_cycle), 32'd6);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_idle", 32'(bus.job_ready), 32'd1);
    check("mid_rst_psel", 32'(bus.PSEL), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    seen_valid = bus.res_valid;
    bus.operation_done = 1'b1;   // a stray done must not produce a result while idle
    repeat (4) begin
      @(negedge clk);
      seen_valid = seen_valid | bus.res_valid;
    end
    bus.operation_done = 1'b0;
    check("mid_rst_no_res_valid", 32'(seen_valid), 32'd0);

    // Job 6: width 2 again, but reset cleared the width-written flag, so 0x8 is rewritten.
    send_job(32'h0000_0077, 32'h0, 2'b10, 2'd2, 32'h0);
    check("j6_nwrites", 32'(wr_n), 32'd4);
    check("j6_addr1", wr_addr[1], 32'h8);
    check("j6_data1", wr_data[1], 32'h2);
    check("j6_ctrl_cycle", 32'(hit_cycle), 32'd8);
    finish_job(1, 32'h8765_4321, 2'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ecc_job_sequencer.md
ECC_JOB_SEQUENCER -- requirements
Module: ecc_job_sequencer

Interface
REQ-001 SHALL have parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-002 SHALL have parameter AMBA_WORD, default 32, APB data, job data and result data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum WAIT_DONE cycles before abort (range 4..255).
REQ-004 SHALL use one clock and a synchronous, active-low reset, with ports as below.
REQ-005 clk  input  1  sole clock, all state changes on rising edge.
REQ-006 rst  input  1  synchronous active-low reset.
REQ-007 job_valid  input  1  job offered; job_ready  output  1  job accepted when both high at a clk edge.
REQ-008 job_data  input  AMBA_WORD  DATA_IN payload; job_noise  input  AMBA_WORD  NOISE payload.
REQ-009 job_op  input  2  CTRL opcode (00 encode, 01 decode, 10 full); job_width  input  2  CODEWORD_WIDTH value.
REQ-010 PADDR  output  AMBA_ADDR_WIDTH; PWDATA  output  AMBA_WORD; PSEL, PENABLE, PWRITE  output  1 each; APB master toward ECC block.
REQ-011 data_out  input  AMBA_WORD; operation_done  input  1; num_of_errors  input  2; ECC block results.
REQ-012 res_valid  output  1; res_ready  input  1; result taken when both high at a clk edge.
REQ-013 res_data  output  AMBA_WORD; res_errors  output  2; res_timeout  output  1; busy  output  1 (high when not IDLE).

Function
REQ-014 SHALL implement states IDLE, SETUP, ACCESS, WAIT_DONE, RESP; job_ready SHALL equal (state==IDLE).
REQ-015 On accept, SHALL latch job fields and enter SETUP next cycle; write list: DATA_IN 0x4, CODEWORD_WIDTH 0x8 (conditional), NOISE 0xC, CTRL 0x0, in that order.
REQ-016 CODEWORD_WIDTH write SHALL occur only if no width written since reset or job_width differs from last written width.
REQ-017 SETUP cycle: PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA of current entry; ACCESS cycle: same with PENABLE=1; no wait states.
REQ-018 After ACCESS SHALL go to SETUP of next entry, or WAIT_DONE after CTRL; outside SETUP/ACCESS PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0.
REQ-019 Job accept to CTRL ACCESS SHALL be 8 cycles (4 writes) or 6 cycles (3 writes), counting first SETUP as cycle 1.
REQ-020 In WAIT_DONE, operation_done=1 SHALL capture data_out into res_data and num_of_errors into res_errors, res_timeout=0, and enter RESP next cycle.
REQ-021 In RESP, res_valid=1 with stable res_* until res_ready=1; then IDLE next cycle; res_valid=0 in all other states.
REQ-022 A new job SHALL be accepted no earlier than the cycle after RESP exit (no overlap).
REQ-023 num_of_errors=3 at capture SHALL be passed unchanged; sequencer performs no result filtering.

Reset
REQ-024 rst=0 at a clk edge SHALL force IDLE, abort any APB transfer, clear the width-written flag, and drive all outputs 0 except job_ready=1.
REQ-025 Reset mid-operation SHALL discard the job and any pending result without emitting res_valid.

Configuration
REQ-026 Macro ECC_SEQ_TIMEOUT_EN defined: WAIT_DONE cycle counter; reaching TIMEOUT_CYCLES without operation_done SHALL enter RESP with res_timeout=1, res_data=0, res_errors=0.
REQ-027 Macro ECC_SEQ_TIMEOUT_EN undefined: no counter; WAIT_DONE SHALL wait indefinitely; res_timeout SHALL be constant 0.

Verification
REQ-028 First job after reset, data 0x0000_00A5, width 2, noise 0, op 10 -> 4 writes to 0x4,0x8,0xC,0x0, CTRL PWDATA 0x2, CTRL ACCESS in cycle 8.
REQ-029 Second job, same width 2 -> 3 writes (0x4,0xC,0x0), no 0x8 write; then width 1 -> 0x8 write with PWDATA 0x1.
REQ-030 operation_done 3 cycles after CTRL ACCESS, data_out 0x1234_5678, errors 1 -> res_valid with res_data 0x1234_5678, res_errors 1, res_timeout 0.
REQ-031 res_ready held low 5 cycles in RESP -> res_valid and res_data stable, job_ready 0, new job_valid not accepted.
REQ-032 ECC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, operation_done never high -> RESP after 16 WAIT_DONE cycles, res_timeout 1, res_data 0.
REQ-033 rst=0 during NOISE ACCESS -> next cycle IDLE, PSEL 0, res_valid never high; following job width 2 rewrites 0x8.
